// File: rtl/psd_pkg.sv
// Shared definitions for the psd divider / multiplier pair.
// Operand width, multiplier state type and iteration counter width live here.
package psd_pkg;

    localparam int PSD_WIDTH = 32;
    localparam int PSD_CNT_W = $clog2(PSD_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } psd_mul_state_t;

endpackage

// File: rtl/psdmultiply.sv
// Sequential shift-add multiply-accumulate: product = multiplicand * multiplier + addend.
// One iteration per clock over WIDTH cycles, with a start/busy/done handshake.
module psdmultiply
    import psd_pkg::*;
#(
    parameter int WIDTH = PSD_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     addend,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done,
    output psd_mul_state_t       state
);

    // Handshake: start is sampled only in IDLE; busy is high for the WIDTH
    // RUN cycles; done pulses for one cycle once product holds the new result.

    localparam int CW = $clog2(WIDTH + 1);

    psd_mul_state_t          state_q, state_d;
    logic [WIDTH-1:0]        ra_q, ra_d;
    logic [2*WIDTH:0]        acc_q, acc_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [2*WIDTH-1:0]      product_q, product_d;

    logic [WIDTH:0]          high_sum;
    logic [2*WIDTH:0]        acc_shift;

    always_comb begin
        state_d   = state_q;
        ra_d      = ra_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        // The addend preloaded in the high half drifts down into the low
        // WIDTH bits over the iterations, which is what makes +C come out exact.
        if (acc_q[0]) begin
            high_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, ra_q};
        end else begin
            high_sum = acc_q[2*WIDTH:WIDTH];
        end
        acc_shift = {1'b0, high_sum, acc_q[WIDTH-1:1]};

        case (state_q)
            IDLE: begin
                if (start) begin
                    ra_d    = multiplicand;
                    acc_d   = {1'b0, addend, multiplier};
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_shift;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    product_d = acc_shift[2*WIDTH-1:0];
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            ra_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            ra_q      <= ra_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign state   = state_q;

endmodule
